// File: rtl/cd_prod_accum.sv
`default_nettype none
// ============================================================================
// Module   : cd_prod_accum
// Purpose  : Frame accumulator for unsigned carry-disregard approximate
//            products. Sums up to FRAME_LEN products (or fewer if in_last
//            closes the frame early) and presents sum, count and a sticky
//            overflow flag on a valid/ready output.
// Options  : CD_ACC_SAT_EN defined   -> saturating accumulation on overflow
//            CD_ACC_SAT_EN undefined -> modular wrap on overflow
// Revision : 1.0 - initial release
// ============================================================================
module cd_prod_accum #(
    parameter int PW        = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0]       c_frame_len = 8'(FRAME_LEN);
    localparam logic [ACC_W-1:0] c_acc_max   = '1;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               w_accept;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_next;
    logic [7:0]         w_cnt_inc;

    // Datapath: one extra bit above the accumulator catches the carry-out.
    always_comb begin
        w_accept  = in_valid & in_ready_q;
        w_sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, in_prod};
        w_carry   = w_sum[ACC_W];
        w_cnt_inc = cnt_q + 8'd1;
`ifdef CD_ACC_SAT_EN
        // Once clamped, any further nonzero product carries again and re-clamps.
        w_acc_next = w_carry ? c_acc_max : w_sum[ACC_W-1:0];
`else
        w_acc_next = w_sum[ACC_W-1:0];
`endif
    end

    // Next-state logic; acc/cnt are zero in IDLE so the same adder loads the first product.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    acc_d = w_acc_next;
                    cnt_d = w_cnt_inc;
                    ovf_d = ovf_q | w_carry;
                    if ((w_cnt_inc == c_frame_len) || in_last) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs; in_ready stays low for the first
    // IDLE cycle after HOLD so every frame is followed by a two-cycle input gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d != S_HOLD) && (state_q != S_HOLD);
            out_valid_q <= (state_d == S_HOLD);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule
`default_nettype wire
